rf_wb_scheduler: RTL and testbench
==================================

// Module: rf_wb_scheduler
// PURPOSE
//  Schedules and arbitrates the single register-file write port (addr_3/we_3/wd_3) between NREQ writeback sources.
//  Sources are ALU, load unit and CSR unit.
//  Holds a pending-write scoreboard that flags read-after-write hazards on the two read ports for the issue stage.
//  Sits between the execute/writeback units and reg_file; drives reg_file write inputs directly.
// PARAMETERS
//  ADW   5   register address width (2**ADW registers, x0 hard-wired zero)
//  DPW   32  data width
//  NREQ  3   number of writeback requesters (>=2)
// PORTS
//  clk          in   1            clock; all state updates on posedge
//  arst_n       in   1            asynchronous active-low reset
//  req_valid_i  in   NREQ         requester i has a write pending
//  req_ready_o  out  NREQ         requester i granted this cycle
//  req_addr_i   in   NREQ*ADW     destination register per requester
//  req_data_i   in   NREQ*DPW     write data per requester
//  stall_i      in   1            freeze grants (no handshake fires)
//  rsv_valid_i  in   1            issue stage reserves a destination
//  rsv_addr_i   in   ADW          destination being reserved
//  flush_i      in   1            pipeline flush: clear scoreboard
//  rd_addr_1    in   ADW          read address port 1 (mirrors reg_file addr_1)
//  rd_addr_2    in   ADW          read address port 2
//  rf_rd_1      in   DPW          reg_file rd_1
//  rf_rd_2      in   DPW          reg_file rd_2
//  rd_1_o       out  DPW          read data port 1 to consumer
//  rd_2_o       out  DPW          read data port 2 to consumer
//  haz_1_o      out  1            port 1 source has pending write
//  haz_2_o      out  1            port 2 source has pending write
//  addr_3       out  ADW          reg_file write address (registered)
//  we_3         out  1            reg_file write enable (registered)
//  wd_3         out  DPW          reg_file write data (registered)
// BEHAVIOUR
//  Reset:
//   - addr_3=0, we_3=0, wd_3=0, busy[*]=0, rr_ptr=0.
//   - req_ready_o is combinational and is all-zero while arst_n=0.
//  Arbitration:
//   - Round-robin over req_valid_i, searching from rr_ptr upward and wrapping at NREQ-1 -> 0.
//   - At most one req_ready_o bit is high; never when stall_i or flush_i.
//   - Fire = valid & ready. On fire with grant g, rr_ptr <= (g+1) mod NREQ. rr_ptr holds otherwise.
//   - Ready may assert only with valid. A requester keeps valid/addr/data stable until fired.
//  Write stage:
//   - On fire: addr_3<=addr_g, wd_3<=data_g, we_3<=(addr_g!=0). With no fire: we_3<=0, addr_3/wd_3 hold.
//   - Latency: fire at edge N -> we_3 high in cycle N..N+1 -> reg_file writes at edge N+1.
//   - Maximum throughput is 1 write/cycle.
//   - A write to x0 fires the handshake but never asserts we_3.
//  Scoreboard busy[2**ADW]:
//   - Set: rsv_valid_i & rsv_addr_i!=0 sets busy[rsv_addr_i] at the next edge.
//   - Clear: we_3 clears busy[addr_3] at the next edge.
//   - Set and clear on the same address in the same cycle: set wins (newer reservation).
//   - busy[0] is always 0.
//   - flush_i clears all busy bits at the next edge. If set coincides with flush, flush wins.
//   - flush_i does not cancel a write already in addr_3/we_3/wd_3; that write commits.
//   - haz_k_o = busy[rd_addr_k] (combinational). Modified by RF_BYPASS_EN.
//  Async reset mid-write: we_3 drops immediately, no commit. Requesters must re-present after reset.
// CONFIGURATION
//  RF_BYPASS_EN defined:
//   - rd_k_o = wd_3 when we_3 & addr_3==rd_addr_k & rd_addr_k!=0; otherwise rd_k_o = rf_rd_k.
//   - haz_k_o is forced 0 under the same match condition.
//  RF_BYPASS_EN undefined:
//   - rd_k_o = rf_rd_k.
//   - haz_k_o = busy[rd_addr_k]; consumer waits one extra cycle.
// STRUCTURE
//  Package rf_ctrl_pkg:
//   - Default localparams ADW/DPW/NREQ.
//   - Types addr_t = logic[ADW-1:0], data_t = logic[DPW-1:0].
//   - Struct wb_req_t {addr_t addr; data_t data;}.
//  Sub-module rr_arbiter #(N):
//   - Inputs: req, ptr, en. Outputs: one-hot gnt and gnt index.
//   - Purely combinational. rr_ptr register stays in rf_wb_scheduler.
//  Top level holds the write-stage registers, the scoreboard, and the bypass muxes.
// TESTING
//  1. Reset: assert arst_n=0 mid-run -> we_3=0, addr_3=0, wd_3=0, haz_*=0, req_ready_o=0 immediately.
//  2. Single write: req0 addr=5 data=32'hDEAD_BEEF fires at edge N.
//     -> we_3=1, addr_3=5 after edge N; reg_file x5 reads 32'hDEAD_BEEF after edge N+1.
//  3. Round-robin: all 3 valid, rr_ptr=0 -> grants 0,1,2,0 over 4 cycles.
//     Drop req1 -> sequence 0,2,0.
//  4. x0 write: req2 addr=0 data=32'h1234 -> ready=1, we_3 stays 0, x0 reads 0.
//  5. Scoreboard:
//     - rsv addr=7 -> haz_1_o=1 with rd_addr_1=7.
//     - Write to 7 -> haz clears the edge after we_3.
//     - rsv 7 with we_3 to 7 in the same cycle -> busy[7] stays 1.
//     - flush_i -> all haz 0.
//  6. Bypass (RF_BYPASS_EN): we_3 to x9 with rd_addr_1=9 -> rd_1_o=wd_3 and haz_1_o=0 in the same cycle.
//     Without the macro: rd_1_o=rf_rd_1 (old value), haz_1_o=1.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared defaults and types for the register-file write-back scheduler.
// The optional read bypass is selected with the RF_BYPASS_EN macro in rf_wb_scheduler.
package rf_ctrl_pkg;
  localparam int unsigned ADW  = 5;
  localparam int unsigned DPW  = 32;
  localparam int unsigned NREQ = 3;

  typedef logic [ADW-1:0] addr_t;
  typedef logic [DPW-1:0] data_t;

  typedef struct packed {
    addr_t addr;
    data_t data;
  } wb_req_t;

  // Round-robin successor of grant g among n requesters.
  function automatic int unsigned rr_next(int unsigned g, int unsigned n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction
endpackage

// File: rtl/rf_wb_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches req from ptr upward, wrapping at N-1.
// Produces a one-hot grant and its index; the pointer register lives in the caller.
module rr_arbiter #(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);
  logic [PW:0] pos;
  logic        found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // One extra bit so ptr+k can exceed N-1 before the wrap is subtracted.
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= (PW+1)'(N)) pos = pos - (PW+1)'(N);
      if (en && !found && req[pos[PW-1:0]]) begin
        found                = 1'b1;
        gnt[pos[PW-1:0]]     = 1'b1;
        gnt_idx              = pos[PW-1:0];
      end
    end
  end
endmodule

// File: rtl/rf_wb_scheduler.sv
// Arbitrates writeback sources onto reg_file write port 3 and tracks pending writes.
// Define RF_BYPASS_EN to forward the in-flight write (wd_3) onto the read ports.
module rf_wb_scheduler #(
  parameter int unsigned ADW  = rf_ctrl_pkg::ADW,
  parameter int unsigned DPW  = rf_ctrl_pkg::DPW,
  parameter int unsigned NREQ = rf_ctrl_pkg::NREQ
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic [NREQ-1:0]     req_valid_i,
  output logic [NREQ-1:0]     req_ready_o,
  input  logic [NREQ*ADW-1:0] req_addr_i,
  input  logic [NREQ*DPW-1:0] req_data_i,
  input  logic                stall_i,
  input  logic                rsv_valid_i,
  input  logic [ADW-1:0]      rsv_addr_i,
  input  logic                flush_i,
  input  logic [ADW-1:0]      rd_addr_1,
  input  logic [ADW-1:0]      rd_addr_2,
  input  logic [DPW-1:0]      rf_rd_1,
  input  logic [DPW-1:0]      rf_rd_2,
  output logic [DPW-1:0]      rd_1_o,
  output logic [DPW-1:0]      rd_2_o,
  output logic                haz_1_o,
  output logic                haz_2_o,
  output logic [ADW-1:0]      addr_3,
  output logic                we_3,
  output logic [DPW-1:0]      wd_3
);
  import rf_ctrl_pkg::rr_next;

  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NREG = 2 ** ADW;

  logic [PW-1:0]   rr_ptr;
  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_idx;
  logic            arb_en;
  logic            fire;
  logic [ADW-1:0]  sel_addr;
  logic [DPW-1:0]  sel_data;
  logic [NREG-1:0] busy;

  // Grants are suppressed during reset so ready is low while arst_n is asserted.
  assign arb_en = arst_n && !stall_i && !flush_i;

  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .req    (req_valid_i),
    .ptr    (rr_ptr),
    .en     (arb_en),
    .gnt    (gnt),
    .gnt_idx(gnt_idx)
  );

  assign req_ready_o = gnt;
  assign fire        = |gnt;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr_i[i*ADW +: ADW];
        sel_data = req_data_i[i*DPW +: DPW];
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rr_ptr <= '0;
      addr_3 <= '0;
      we_3   <= 1'b0;
      wd_3   <= '0;
    end else begin
      we_3 <= fire && (sel_addr != '0);
      if (fire) begin
        addr_3 <= sel_addr;
        wd_3   <= sel_data;
        rr_ptr <= PW'(rr_next(32'(gnt_idx), NREQ));
      end
    end
  end

  // Set is written after clear so a same-address reservation overrides the commit.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      busy <= '0;
    end else if (flush_i) begin
      busy <= '0;
    end else begin
      if (we_3) busy[addr_3] <= 1'b0;
      if (rsv_valid_i && rsv_addr_i != '0) busy[rsv_addr_i] <= 1'b1;
    end
  end

`ifdef RF_BYPASS_EN
  logic fwd_1, fwd_2;
  assign fwd_1   = we_3 && (addr_3 == rd_addr_1) && (rd_addr_1 != '0);
  assign fwd_2   = we_3 && (addr_3 == rd_addr_2) && (rd_addr_2 != '0);
  assign rd_1_o  = fwd_1 ? wd_3 : rf_rd_1;
  assign rd_2_o  = fwd_2 ? wd_3 : rf_rd_2;
  assign haz_1_o = busy[rd_addr_1] && !fwd_1;
  assign haz_2_o = busy[rd_addr_2] && !fwd_2;
`else
  assign rd_1_o  = rf_rd_1;
  assign rd_2_o  = rf_rd_2;
  assign haz_1_o = busy[rd_addr_1];
  assign haz_2_o = busy[rd_addr_2];
`endif
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Bench for rf_wb_scheduler: directed scenarios then random traffic against a
// behavioural model of arbitration, write stage, scoreboard and register file.
module tb_rf_wb_scheduler;
  import rf_ctrl_pkg::*;

  localparam int unsigned NR   = NREQ;
  localparam int unsigned NRG  = 2 ** ADW;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               arst_n = 1'b1;
  logic [NR-1:0]      req_valid = '0;
  logic [NR-1:0]      req_ready;
  logic [NR*ADW-1:0]  req_addr = '0;
  logic [NR*DPW-1:0]  req_data = '0;
  logic               stall = 1'b0, rsv_valid = 1'b0, flush = 1'b0;
  addr_t              rsv_addr = '0, rd_addr_1 = '0, rd_addr_2 = '0;
  data_t              rf_rd_1, rf_rd_2, rd_1, rd_2, wd_3;
  logic               haz_1, haz_2, we_3;
  addr_t              addr_3;

  always #5 clk = ~clk;

  rf_wb_scheduler #(.ADW(ADW), .DPW(DPW), .NREQ(NR)) dut (
    .clk(clk), .arst_n(arst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_data_i(req_data), .stall_i(stall),
    .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr), .flush_i(flush),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2), .rf_rd_1(rf_rd_1), .rf_rd_2(rf_rd_2),
    .rd_1_o(rd_1), .rd_2_o(rd_2), .haz_1_o(haz_1), .haz_2_o(haz_2),
    .addr_3(addr_3), .we_3(we_3), .wd_3(wd_3)
  );

  // Stand-in reg_file driven by the DUT write port; x0 reads zero.
  data_t rf_mem [NRG] = '{default: '0};
  always @(posedge clk) if (we_3 && addr_3 != '0) rf_mem[addr_3] <= wd_3;
  assign rf_rd_1 = (rd_addr_1 == '0) ? '0 : rf_mem[rd_addr_1];
  assign rf_rd_2 = (rd_addr_2 == '0) ? '0 : rf_mem[rd_addr_2];

  // Stimulus intent (copied to DUT inputs at each falling edge).
  logic    s_v [NR];
  wb_req_t s_req [NR];
  logic    s_stall, s_flush, s_rsv_v;
  addr_t   s_rsv_a, s_rd1, s_rd2;

  // Reference model state.
  int      m_ptr;
  logic    m_busy [NRG];
  logic    m_we;
  addr_t   m_a3;
  data_t   m_wd;
  data_t   m_mem [NRG];

  // Observations captured in the most recent step.
  logic [NR-1:0] o_rdy;
  logic          o_we, o_haz1;
  addr_t         o_a3;
  data_t         o_wd, o_rd1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant();
    if (s_stall || s_flush) return -1;
    for (int k = 0; k < int'(NR); k++)
      if (s_v[(m_ptr + k) % int'(NR)]) return (m_ptr + k) % int'(NR);
    return -1;
  endfunction

  function automatic data_t exp_rd(addr_t a);
    if (BYP && m_we && m_a3 == a && a != '0) return m_wd;
    return (a == '0) ? '0 : m_mem[a];
  endfunction

  function automatic logic exp_haz(addr_t a);
    if (BYP && m_we && m_a3 == a && a != '0) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic step();
    int g;
    @(negedge clk);
    for (int i = 0; i < int'(NR); i++) begin
      req_valid[i]           = s_v[i];
      req_addr[i*ADW +: ADW] = s_req[i].addr;
      req_data[i*DPW +: DPW] = s_req[i].data;
    end
    stall = s_stall; flush = s_flush; rsv_valid = s_rsv_v; rsv_addr = s_rsv_a;
    rd_addr_1 = s_rd1; rd_addr_2 = s_rd2;
    #1;
    g = exp_grant();
    o_rdy = req_ready; o_we = we_3; o_a3 = addr_3; o_wd = wd_3; o_rd1 = rd_1; o_haz1 = haz_1;
    check("ready", req_ready, (g < 0) ? 0 : (1 << g));
    check("we_3", we_3, m_we);
    check("addr_3", addr_3, m_a3);
    check("wd_3", wd_3, m_wd);
    check("haz_1", haz_1, exp_haz(s_rd1));
    check("haz_2", haz_2, exp_haz(s_rd2));
    check("rd_1", rd_1, exp_rd(s_rd1));
    check("rd_2", rd_2, exp_rd(s_rd2));
    @(posedge clk);
    if (m_we) m_mem[m_a3] = m_wd;
    if (s_flush) begin
      for (int r = 0; r < int'(NRG); r++) m_busy[r] = 1'b0;
    end else begin
      if (m_we) m_busy[m_a3] = 1'b0;
      if (s_rsv_v && s_rsv_a != '0) m_busy[s_rsv_a] = 1'b1;
    end
    if (g >= 0) begin
      m_we  = (s_req[g].addr != '0);
      m_a3  = s_req[g].addr;
      m_wd  = s_req[g].data;
      s_v[g] = 1'b0;
      m_ptr = (g + 1) % int'(NR);
    end else begin
      m_we = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_we_3", we_3, 0);
    check("rst_addr_3", addr_3, 0);
    check("rst_wd_3", wd_3, 0);
    check("rst_haz_1", haz_1, 0);
    check("rst_haz_2", haz_2, 0);
    req_valid = '0; stall = 1'b0; flush = 1'b0; rsv_valid = 1'b0;
    for (int i = 0; i < int'(NR); i++) s_v[i] = 1'b0;
    s_stall = 1'b0; s_flush = 1'b0; s_rsv_v = 1'b0;
    m_ptr = 0; m_we = 1'b0; m_a3 = '0; m_wd = '0;
    for (int r = 0; r < int'(NRG); r++) m_busy[r] = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  logic [NR-1:0] rr_all  [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [NR-1:0] rr_drop [3] = '{3'b001, 3'b100, 3'b001};

  initial begin
    for (int i = 0; i < int'(NR); i++) begin
      s_v[i] = 1'b0; s_req[i] = '0;
    end
    for (int r = 0; r < int'(NRG); r++) m_mem[r] = '0;
    s_stall = 1'b0; s_flush = 1'b0; s_rsv_v = 1'b0; s_rsv_a = '0; s_rd1 = '0; s_rd2 = '0;
    do_reset();

    // Single write to x5.
    s_v[0] = 1'b1; s_req[0] = '{addr: 5'd5, data: 32'hDEAD_BEEF}; s_rd1 = 5'd5;
    step(); check("sw_ready", o_rdy, 3'b001);
    step(); check("sw_we", o_we, 1); check("sw_addr", o_a3, 5); check("sw_wd", o_wd, 32'hDEAD_BEEF);
    step(); check("sw_readback", o_rd1, 32'hDEAD_BEEF);

    // Write to x0 handshakes but never enables the port.
    s_v[2] = 1'b1; s_req[2] = '{addr: 5'd0, data: 32'h1234}; s_rd1 = 5'd0;
    step(); check("x0_ready", o_rdy, 3'b100);
    step(); check("x0_we", o_we, 0); check("x0_read", o_rd1, 0);

    // Round robin with all requesters valid; reserve x3 so reset has a hazard to clear.
    s_rsv_v = 1'b1; s_rsv_a = 5'd3; s_rd1 = 5'd3;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < int'(NR); i++)
        if (!s_v[i]) begin s_v[i] = 1'b1; s_req[i] = '{addr: addr_t'(10 + i), data: $urandom}; end
      step(); s_rsv_v = 1'b0;
      check("rr_all", o_rdy, rr_all[k]);
    end
    do_reset();

    // Round robin with requester 1 idle.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < int'(NR); i += 2)
        if (!s_v[i]) begin s_v[i] = 1'b1; s_req[i] = '{addr: addr_t'(20 + i), data: $urandom}; end
      step();
      check("rr_drop", o_rdy, rr_drop[k]);
    end

    // Scoreboard on x7.
    s_rsv_v = 1'b1; s_rsv_a = 5'd7; s_rd1 = 5'd7;
    step(); s_rsv_v = 1'b0;
    s_v[0] = 1'b1; s_req[0] = '{addr: 5'd7, data: 32'h7777_0001};
    step(); check("sb_set", o_haz1, 1);
    step(); check("sb_inflight", o_haz1, BYP ? 0 : 1);
    s_v[0] = 1'b1; s_req[0] = '{addr: 5'd7, data: 32'h7777_0002};
    step(); check("sb_cleared", o_haz1, 0);
    s_rsv_v = 1'b1; s_rsv_a = 5'd7;
    step(); s_rsv_v = 1'b0; check("sb_coincide_we", o_we, 1);
    step(); check("sb_set_wins", o_haz1, 1);
    s_flush = 1'b1;
    step(); s_flush = 1'b0;
    step(); check("sb_flush", o_haz1, 0);

    // Read of a register while its write is on the port.
    s_rsv_v = 1'b1; s_rsv_a = 5'd9; s_rd1 = 5'd9;
    s_v[0] = 1'b1; s_req[0] = '{addr: 5'd9, data: 32'hCAFE_0009};
    step(); s_rsv_v = 1'b0;
    step();
    check("byp_rd", o_rd1, BYP ? 32'hCAFE_0009 : 32'h0);
    check("byp_haz", o_haz1, BYP ? 0 : 1);

    // Random traffic.
    repeat (1500) begin
      for (int i = 0; i < int'(NR); i++)
        if (!s_v[i] && $urandom_range(2) == 0) begin
          s_v[i] = 1'b1;
          s_req[i].addr = addr_t'($urandom_range(11));
          s_req[i].data = $urandom;
        end
      s_stall = ($urandom_range(7) == 0);
      s_flush = ($urandom_range(19) == 0);
      s_rsv_v = ($urandom_range(2) == 0);
      s_rsv_a = addr_t'($urandom_range(11));
      s_rd1   = addr_t'($urandom_range(11));
      s_rd2   = addr_t'($urandom_range(11));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
